// File: rtl/onehot_decoder_stream_pkg.sv
// rtl/onehot_decoder_stream_pkg.sv - shared mode encodings and reset constants
//
// Purpose: mode encodings for the decoder and the code whose one-hot pattern
//          the output register holds out of reset.
package onehot_decoder_stream_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT    = 2'b00,
        MODE_THERM     = 2'b01,
        MODE_INVONEHOT = 2'b10,
        MODE_RSVD      = 2'b11
    } mode_e;

    // The output register resets to the one-hot pattern of this code.
    localparam int unsigned RESET_CODE = 0;

endpackage

// File: rtl/onehot_decoder_stream_if.sv
// rtl/onehot_decoder_stream_if.sv - code-in / pattern-out handshake bundle
//
// Purpose: groups the input code stream and the output pattern stream.
// Signals: in_valid/in_ready/in_code/in_mode   code stream (producer -> block)
//          out_valid/out_ready/out_data        pattern stream (block -> consumer)
// Modports: master = producer/consumer side, slave = decoder block.
interface onehot_decoder_stream_if #(
    parameter int IN_W = 3
);
    localparam int OUT_W = 2 ** IN_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_code, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_code, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/onehot_decode_comb.sv
// rtl/onehot_decode_comb.sv - combinational code-to-pattern decoder
//
// Purpose: maps an IN_W-bit code to a 2**IN_W-bit pattern.
// Ports:   code    code to decode
//          mode    00 one-hot, 01 thermometer, 10 inverted one-hot, 11 reserved
//          pattern decoded pattern (reserved mode decodes as one-hot)
//          rsvd    high when mode is the reserved encoding
module onehot_decode_comb
    import onehot_decoder_stream_pkg::*;
#(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      code,
    input  logic [1:0]           mode,
    output logic [2**IN_W-1:0]   pattern,
    output logic                 rsvd
);

    localparam int OUT_W = 2 ** IN_W;

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;

    always_comb begin
        onehot = OUT_W'(1) << code;
        // Bits 0..k set: (1 << (k+1)) - 1. For the top code the shift drops
        // out of the OUT_W-bit vector and the subtraction wraps to all ones.
        therm  = (onehot << 1) - OUT_W'(1);
        rsvd   = 1'b0;
        case (mode_e'(mode))
            MODE_ONEHOT:    pattern = onehot;
            MODE_THERM:     pattern = therm;
            MODE_INVONEHOT: pattern = ~onehot;
            default: begin
                pattern = onehot;
                rsvd    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/onehot_decoder_stream.sv
// rtl/onehot_decoder_stream.sv - streaming one-hot/thermometer decoder with transfer counter
//
// Purpose: decodes accepted codes into a one-entry output register with a
//          valid/ready handshake, and counts accepted transfers.
// Ports:   clk, rst_n  clock, asynchronous active-low reset
//          bus         slave side of the code/pattern handshake bundle
//          cnt_clr     synchronous clear of cnt, ovf and err
//          cnt         accepted-transfer counter
//          ovf         sticky counter wrap/saturation flag
//          err         sticky reserved-mode flag
module onehot_decoder_stream
    import onehot_decoder_stream_pkg::*;
#(
    parameter int IN_W     = 3,
    parameter int CNT_W    = 8,
    parameter int CNT_INIT = 1,
    parameter bit CNT_SAT  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_decoder_stream_if.slave bus,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt,
    output logic                  ovf,
    output logic                  err
);

    localparam int OUT_W = 2 ** IN_W;
    localparam logic [OUT_W-1:0] RST_PATTERN = OUT_W'(1) << RESET_CODE;
    localparam logic [CNT_W-1:0] CNT_INIT_V  = CNT_W'(CNT_INIT);

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;
    logic             err_q,       err_d;

    logic             in_ready;
    logic             accept;
    logic [OUT_W-1:0] dec_pattern;
    logic             dec_rsvd;
    logic [CNT_W:0]   cnt_inc;

    onehot_decode_comb #(
        .IN_W (IN_W)
    ) u_decode (
        .code    (bus.in_code),
        .mode    (bus.in_mode),
        .pattern (dec_pattern),
        .rsvd    (dec_rsvd)
    );

    // The register frees up when empty or when its content leaves this cycle;
    // in_valid is deliberately not part of this term.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_pattern;
        end else if (bus.out_ready) begin
            // Drained with nothing new: data holds its last value.
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (cnt_clr) begin
            // Clear wins over a same-cycle accept, including its err update.
            cnt_d = CNT_INIT_V;
            ovf_d = 1'b0;
            err_d = 1'b0;
        end else if (accept) begin
            err_d = err_q | dec_rsvd;
            if (cnt_inc[CNT_W]) begin
                ovf_d = 1'b1;
                cnt_d = CNT_SAT ? cnt_q : cnt_inc[CNT_W-1:0];
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= RST_PATTERN;
            cnt_q       <= CNT_INIT_V;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign cnt           = cnt_q;
    assign ovf           = ovf_q;
    assign err           = err_q;

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// tb/tb_onehot_decoder_stream.sv - scoreboard bench for onehot_decoder_stream
module tb_onehot_decoder_stream;
    import onehot_decoder_stream_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cnt_clr_m, cnt_clr_w, cnt_clr_s;
    logic [7:0] cnt_m;
    logic [3:0] cnt_w, cnt_s;
    logic       ovf_m, ovf_w, ovf_s;
    logic       err_m, err_w, err_s;

    onehot_decoder_stream_if #(.IN_W(3)) bus_m ();
    onehot_decoder_stream_if #(.IN_W(3)) bus_w ();
    onehot_decoder_stream_if #(.IN_W(3)) bus_s ();

    onehot_decoder_stream #(.IN_W(3), .CNT_W(8), .CNT_INIT(1), .CNT_SAT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_m.slave),
        .cnt_clr(cnt_clr_m), .cnt(cnt_m), .ovf(ovf_m), .err(err_m)
    );

    onehot_decoder_stream #(.IN_W(3), .CNT_W(4), .CNT_INIT(1), .CNT_SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus_w.slave),
        .cnt_clr(cnt_clr_w), .cnt(cnt_w), .ovf(ovf_w), .err(err_w)
    );

    onehot_decoder_stream #(.IN_W(3), .CNT_W(4), .CNT_INIT(1), .CNT_SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.slave),
        .cnt_clr(cnt_clr_s), .cnt(cnt_s), .ovf(ovf_s), .err(err_s)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: one pop per completed output handshake.
    always @(negedge clk) begin
        if (rst_n && bus_m.out_valid && bus_m.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {24'd0, bus_m.out_data}, 32'hFFFF_FFFF);
            end else begin
                check("out_data", {24'd0, bus_m.out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive a code, wait (bounded) for acceptance, record its expected pattern.
    // Returns 1 time unit after the accepting edge with in_valid still high.
    task automatic send(input logic [2:0] code, input logic [1:0] mode, input logic [7:0] exp);
        int n;
        n = 0;
        bus_m.in_valid = 1'b1;
        bus_m.in_code  = code;
        bus_m.in_mode  = mode;
        @(negedge clk);
        while (!bus_m.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus_m.in_ready) check("accept_wait", 32'd0, 32'd1);
        else exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_m.in_valid = 0; bus_m.in_code = 0; bus_m.in_mode = 0; bus_m.out_ready = 1;
        bus_w.in_valid = 0; bus_w.in_code = 0; bus_w.in_mode = 0; bus_w.out_ready = 1;
        bus_s.in_valid = 0; bus_s.in_code = 0; bus_s.in_mode = 0; bus_s.out_ready = 1;
        cnt_clr_m = 0; cnt_clr_w = 0; cnt_clr_s = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus_m.out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, bus_m.out_data},  32'h01);
        check("rst_cnt",       {24'd0, cnt_m},           32'd1);
        check("rst_ovf",       {31'd0, ovf_m},           32'd0);
        check("rst_err",       {31'd0, err_m},           32'd0);
        check("rst_in_ready",  {31'd0, bus_m.in_ready},  32'd1);
        rst_n = 1'b1;
        idle(1);

        // 4-bit counters: wrap vs saturate over 16 back-to-back accepts.
        bus_w.in_valid = 1'b1;
        bus_s.in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            check("wrap_cnt", {28'd0, cnt_w}, (1 + i) % 16);
            check("wrap_ovf", {31'd0, ovf_w}, (i >= 15) ? 32'd1 : 32'd0);
            check("sat_cnt",  {28'd0, cnt_s}, (1 + i > 15) ? 32'd15 : 32'(1 + i));
            check("sat_ovf",  {31'd0, ovf_s}, (i >= 15) ? 32'd1 : 32'd0);
        end
        bus_w.in_valid = 1'b0;
        bus_s.in_valid = 1'b0;
        idle(2);

        // One-hot codes 0..7 at full throughput.
        for (int k = 0; k < 8; k++) send(3'(k), MODE_ONEHOT, onehot_tbl[k]);
        bus_m.in_valid = 1'b0;
        idle(2);
        check("cnt_after_onehot", {24'd0, cnt_m}, 32'd9);
        check("ovf_after_onehot", {31'd0, ovf_m}, 32'd0);

        send(3'd3, MODE_THERM, 8'h0F);
        send(3'd5, MODE_INVONEHOT, 8'hDF);
        bus_m.in_valid = 1'b0;
        idle(2);
        check("err_after_modes", {31'd0, err_m}, 32'd0);
        check("cnt_after_modes", {24'd0, cnt_m}, 32'd11);

        // Stall: 0x40 held while code 2 waits; in_code wiggles must not matter.
        bus_m.out_ready = 1'b0;
        send(3'd6, MODE_ONEHOT, 8'h40);
        for (int i = 0; i < 4; i++) begin
            bus_m.in_code = 3'(i + 1);
            @(negedge clk);
            check("stall_in_ready",  {31'd0, bus_m.in_ready},  32'd0);
            check("stall_out_valid", {31'd0, bus_m.out_valid}, 32'd1);
            check("stall_out_data",  {24'd0, bus_m.out_data},  32'h40);
            check("stall_cnt",       {24'd0, cnt_m},           32'd12);
        end
        @(posedge clk);
        #1;
        bus_m.out_ready = 1'b1;
        send(3'd2, MODE_ONEHOT, 8'h04);
        bus_m.in_valid = 1'b0;
        idle(2);
        check("cnt_after_stall", {24'd0, cnt_m}, 32'd13);

        // Reserved mode, then clear colliding with accepts.
        send(3'd6, MODE_RSVD, 8'h40);
        bus_m.in_valid = 1'b0;
        check("err_rsvd", {31'd0, err_m}, 32'd1);
        check("cnt_rsvd", {24'd0, cnt_m}, 32'd14);
        cnt_clr_m = 1'b1;
        send(3'd1, MODE_ONEHOT, 8'h02);
        cnt_clr_m = 1'b0;
        bus_m.in_valid = 1'b0;
        check("clr_cnt", {24'd0, cnt_m}, 32'd1);
        check("clr_ovf", {31'd0, ovf_m}, 32'd0);
        check("clr_err", {31'd0, err_m}, 32'd0);
        cnt_clr_m = 1'b1;
        send(3'd3, MODE_RSVD, 8'h08);
        cnt_clr_m = 1'b0;
        bus_m.in_valid = 1'b0;
        check("clr_rsvd_err", {31'd0, err_m}, 32'd0);
        check("clr_rsvd_cnt", {24'd0, cnt_m}, 32'd1);
        idle(2);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a stall.
        bus_m.out_ready = 1'b0;
        send(3'd5, MODE_ONEHOT, 8'h20);
        bus_m.in_valid = 1'b0;
        check("pre_rst_out_valid", {31'd0, bus_m.out_valid}, 32'd1);
        check("pre_rst_cnt",       {24'd0, cnt_m},           32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bus_m.out_valid}, 32'd0);
        check("arst_out_data",  {24'd0, bus_m.out_data},  32'h01);
        check("arst_cnt",       {24'd0, cnt_m},           32'd1);
        check("arst_ovf",       {31'd0, ovf_m},           32'd0);
        check("arst_err",       {31'd0, err_m},           32'd0);
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
